// File: rtl/mux8_way16_pkg.sv
// Shared constants and types for the eight-way word selector.
package mux_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int NUM_WAYS      = 8;
    localparam int SEL_W         = 3;

    typedef logic [WIDTH_DEFAULT-1:0] word_t;

endpackage : mux_pkg

// File: rtl/mux8_way16_if.sv
// Bus bundle for the selector: eight candidate words, index, and qualified result.
interface mux8_way16_if
    import mux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] h;
    logic [SEL_W-1:0] sel;
    logic             in_valid;
    logic [WIDTH-1:0] out;
    logic             out_valid;

    modport master (
        output a, b, c, d, e, f, g, h, sel, in_valid,
        input  out, out_valid
    );

    modport slave (
        input  a, b, c, d, e, f, g, h, sel, in_valid,
        output out, out_valid
    );

endinterface : mux8_way16_if

// File: rtl/mux8_way16_mux2.sv
// Two-input word selector; leaf cell of the eight-way selection tree.
module mux2_way16
    import mux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    // sel=0 passes a, sel=1 passes b
    always_comb begin
        if (sel) begin
            y = b;
        end else begin
            y = a;
        end
    end

endmodule : mux2_way16

// File: rtl/mux8_way16.sv
// Eight-way word selector built as a three-level 2:1 tree, with an optional output register.
module mux8_way16
    import mux_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEFAULT,
    parameter bit REGISTERED = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    mux8_way16_if.slave   bus
);

    logic [WIDTH-1:0] l0_s [NUM_WAYS/2];
    logic [WIDTH-1:0] l1_s [NUM_WAYS/4];
    logic [WIDTH-1:0] sel_word_s;

    // Level 0 resolves sel[0] between adjacent word pairs.
    mux2_way16 #(.WIDTH(WIDTH)) u_l0_0 (.a(bus.a), .b(bus.b), .sel(bus.sel[0]), .y(l0_s[0]));
    mux2_way16 #(.WIDTH(WIDTH)) u_l0_1 (.a(bus.c), .b(bus.d), .sel(bus.sel[0]), .y(l0_s[1]));
    mux2_way16 #(.WIDTH(WIDTH)) u_l0_2 (.a(bus.e), .b(bus.f), .sel(bus.sel[0]), .y(l0_s[2]));
    mux2_way16 #(.WIDTH(WIDTH)) u_l0_3 (.a(bus.g), .b(bus.h), .sel(bus.sel[0]), .y(l0_s[3]));

    mux2_way16 #(.WIDTH(WIDTH)) u_l1_0 (.a(l0_s[0]), .b(l0_s[1]), .sel(bus.sel[1]), .y(l1_s[0]));
    mux2_way16 #(.WIDTH(WIDTH)) u_l1_1 (.a(l0_s[2]), .b(l0_s[3]), .sel(bus.sel[1]), .y(l1_s[1]));

    mux2_way16 #(.WIDTH(WIDTH)) u_l2_0 (.a(l1_s[0]), .b(l1_s[1]), .sel(bus.sel[2]), .y(sel_word_s));

    generate
        if (REGISTERED) begin : g_reg
            logic [WIDTH-1:0] out_r;
            logic             out_valid_r;

            // Capture on qualified cycles; out holds through idle cycles while valid drops.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_r       <= {WIDTH{1'b0}};
                    out_valid_r <= 1'b0;
                end else if (bus.in_valid) begin
                    out_r       <= sel_word_s;
                    out_valid_r <= 1'b1;
                end else begin
                    out_r       <= out_r;
                    out_valid_r <= 1'b0;
                end
            end

            assign bus.out       = out_r;
            assign bus.out_valid = out_valid_r;
        end else begin : g_comb
            logic unused_clk_rst_s;

            assign unused_clk_rst_s = clk ^ rst_n;
            assign bus.out          = sel_word_s;
            assign bus.out_valid    = bus.in_valid;
        end
    endgenerate

endmodule : mux8_way16

// File: tb/tb_mux8_way16.sv
// Self-checking bench for mux8_way16: registered and combinational builds against a word-array model.
module tb_mux8_way16;
    import mux_pkg::*;

    logic clk;
    logic rst_n;

    mux8_way16_if #(.WIDTH(16)) bus_r ();
    mux8_way16_if #(.WIDTH(16)) bus_c ();

    mux8_way16 #(.WIDTH(16), .REGISTERED(1'b1)) dut_r (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_r.slave)
    );

    mux8_way16 #(.WIDTH(16), .REGISTERED(1'b0)) dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_c.slave)
    );

    int    checks;
    int    failures;
    word_t w [8];
    word_t exp_out;
    logic  exp_valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic drive_words();
        bus_r.a = w[0]; bus_r.b = w[1]; bus_r.c = w[2]; bus_r.d = w[3];
        bus_r.e = w[4]; bus_r.f = w[5]; bus_r.g = w[6]; bus_r.h = w[7];
        bus_c.a = w[0]; bus_c.b = w[1]; bus_c.c = w[2]; bus_c.d = w[3];
        bus_c.e = w[4]; bus_c.f = w[5]; bus_c.g = w[6]; bus_c.h = w[7];
    endtask

    task automatic set_onehot_words();
        for (int i = 0; i < 8; i++) w[i] = 16'h0001 << i;
        drive_words();
    endtask

    // One clock step on the registered build; the model applies the capture rules at the edge.
    task automatic step(input string tag, input logic [2:0] sel, input logic vld, input logic rst);
        logic [2:0] sel_seen;
        logic       vld_seen;
        bus_r.sel      = sel;
        bus_r.in_valid = vld;
        rst_n          = rst;
        sel_seen       = sel;
        vld_seen       = vld;
        @(posedge clk);
        if (!rst) begin
            exp_out   = 16'h0000;
            exp_valid = 1'b0;
        end else if (vld_seen) begin
            exp_out   = w[sel_seen];
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        #1;
        check({tag, "_out"}, bus_r.out, exp_out);
        check({tag, "_valid"}, {15'd0, bus_r.out_valid}, {15'd0, exp_valid});
    endtask

    // Combinational build: output follows inputs with no edge involved.
    task automatic comb_check(input string tag, input logic [2:0] sel, input logic vld);
        bus_c.sel      = sel;
        bus_c.in_valid = vld;
        #1;
        check({tag, "_out"}, bus_c.out, w[sel]);
        check({tag, "_valid"}, {15'd0, bus_c.out_valid}, {15'd0, vld});
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_out   = 16'h0000;
        exp_valid = 1'b0;
        rst_n     = 1'b0;
        bus_r.sel = 3'd0; bus_r.in_valid = 1'b0;
        bus_c.sel = 3'd0; bus_c.in_valid = 1'b0;
        set_onehot_words();
        #2;

        // Reset overrides in_valid, then first capture after release.
        step("rst0", 3'd7, 1'b1, 1'b0);
        step("rst1", 3'd7, 1'b1, 1'b0);
        step("rel", 3'd0, 1'b1, 1'b1);

        step("dir0", 3'd0, 1'b1, 1'b1);
        step("dir3", 3'd3, 1'b1, 1'b1);
        step("dir7", 3'd7, 1'b1, 1'b1);

        for (int i = 0; i < 8; i++) step($sformatf("sweep%0d", i), 3'(i), 1'b1, 1'b1);

        for (int i = 0; i < 8; i++) w[i] = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
        drive_words();
        for (int i = 0; i < 8; i++) step($sformatf("xtalk%0d", i), 3'(i), 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) w[i] = (i % 2 == 0) ? 16'h0000 : 16'hFFFF;
        drive_words();
        for (int i = 0; i < 8; i++) step($sformatf("xtalkn%0d", i), 3'(i), 1'b1, 1'b1);

        set_onehot_words();
        step("hold_cap", 3'd5, 1'b1, 1'b1);
        step("hold0", 3'd2, 1'b0, 1'b1);
        step("hold1", 3'd2, 1'b0, 1'b1);

        step("mid0", 3'd1, 1'b1, 1'b1);
        step("mid1", 3'd4, 1'b1, 1'b1);
        step("midrst", 3'd6, 1'b1, 1'b0);
        step("midres", 3'd6, 1'b1, 1'b1);
        step("midres2", 3'd3, 1'b1, 1'b1);

        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 8; i++) w[i] = 16'($urandom);
            drive_words();
            step($sformatf("rnd%0d", n), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) != 0));
        end

        set_onehot_words();
        comb_check("comb6", 3'd6, 1'b1);
        comb_check("comb6_nv", 3'd6, 1'b0);
        comb_check("comb0", 3'd0, 1'b1);
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 8; i++) w[i] = 16'($urandom);
            drive_words();
            comb_check($sformatf("crnd%0d", n), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mux8_way16

// File: doc/mux8_way16.md
# mux8_way16

Eight-input, 16-bit-wide selector for the datapath layer of the CPU build. It picks one of eight 16-bit words (a..h) using a 3-bit select and presents the chosen word on a registered output with a companion valid flag. It sits between register/ALU sources and their consumers, where a one-cycle registered result is acceptable.

## Interface
Parameters:
- WIDTH, 16, data width of every input word and of out.
- REGISTERED, 1, 1 = registered output (1-cycle latency); 0 = combinational path from inputs to out and out_valid (clk/rst_n unused except for lint).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous and active-low: sampled only on the rising clk edge; 0 = reset.
- a, b, c, d, e, f, g, h  input  WIDTH each  candidate words, indexed 0..7 in that order.
- sel  input  3  word index: 000→a, 001→b, 010→c, 011→d, 100→e, 101→f, 110→g, 111→h.
- in_valid  input  1  qualifies sel and data this cycle.
- out  output  WIDTH  selected word.
- out_valid  output  1  out holds a result captured from an in_valid cycle.

## Operation
- Selection is a pure function: out_next = word[sel]. All eight sel codes are legal; no default or X case exists.
- Selection is bit-exact. No arithmetic, sign handling or width change. Bit i of out equals bit i of the selected input.
- REGISTERED=1:
  - On each rising edge with rst_n=1 and in_valid=1: out ← word[sel], out_valid ← 1.
  - On each rising edge with rst_n=1 and in_valid=0: out holds its previous value, out_valid ← 0.
- REGISTERED=0:
  - out = word[sel] continuously, regardless of in_valid.
  - out_valid = in_valid.
- There is no backpressure. A new in_valid word is accepted every cycle (throughput 1/cycle).

## Timing
- Reset (REGISTERED=1): on a rising edge with rst_n=0, out ← 16'h0000 and out_valid ← 0. Reset overrides in_valid in the same cycle.
- Reset released mid-stream: the first capture happens on the first edge with rst_n=1 and in_valid=1. No stale data is emitted.
- Latency is 1 cycle. A result sampled at edge N is visible after edge N until the next capture.
- sel or data changes between edges have no effect until the next edge.
- The combinational path is at most 3 levels of 2:1 mux per bit (sel[0], then sel[1], then sel[2]).

## Structure
- Shared package mux_pkg holds:
  - WIDTH_DEFAULT = 16
  - NUM_WAYS = 8
  - SEL_W = 3
  - typedef word_t (logic [WIDTH-1:0])
- One sub-module, mux2_way16 (2:1, WIDTH-parameterized). It is instantiated as a tree: 4 leaves on sel[0], 2 on sel[1], 1 on sel[2].
- The top level adds the output register, valid register, reset logic, and the REGISTERED generate branch.

## Test plan
Inputs are a=0001, b=0002, c=0004, d=0008, e=0010, f=0020, g=0040, h=0080 unless a scenario says otherwise.
- Reset: hold rst_n=0 for 2 edges with in_valid=1, sel=111 → out=0000, out_valid=0. Release; next edge with sel=000, in_valid=1 → out=0001, out_valid=1.
- Directed selects: sel=000, 011, 111 on consecutive edges with in_valid=1 → out=0001, 0008, 0080, each one cycle after its sel.
- Exhaustive sweep: sel 0..7, one per edge → out=0001, 0002, 0004, 0008, 0010, 0020, 0040, 0080. Repeat with inputs set to FFFF/0000 alternating → no bit crosstalk between words.
- Hold: capture sel=101 (out=0020), then drop in_valid and change sel to 010 → out stays 0020, out_valid=0 from the next edge.
- Mid-stream reset: stream valid words, assert rst_n=0 for 1 edge → out=0000, out_valid=0 that cycle, and capture resumes normally afterwards.
- REGISTERED=0 build: sel=110 → out=0040 with no clock edge. in_valid toggling drives out_valid in the same delta cycle.
